// File: rtl/uart_apb_cmd_master.sv
// uart_apb_cmd_master: parses 'W'/'R' byte commands from a UART RX stream,
// runs one APB3 transfer per command and returns status/read bytes on TX.
module uart_apb_cmd_master #(
    parameter int          ADDR_WIDTH     = 5,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  CMD_WR         = 8'h57,
    parameter logic [7:0]  CMD_RD         = 8'h52,
    parameter logic [7:0]  ST_OK          = 8'h4B,
    parameter logic [7:0]  ST_ERR         = 8'h45
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [7:0]            PWDATA,
    input  logic [7:0]            PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  BUSY,
    output logic                  DROPPED
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_APB_SETUP,
        S_APB_ACCESS,
        S_SEND_STATUS,
        S_SEND_DATA
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic                  r_err;
    logic [7:0]            r_rdata;
    logic [7:0]            r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_cnt;
    logic                  w_is_cmd;
    logic                  w_timeout;
    logic                  w_getting;

    assign w_is_cmd  = (RX_DATA == CMD_WR) || (RX_DATA == CMD_RD);
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_getting = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign PADDR     = r_addr;
    assign PWDATA    = r_wdata;

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus APB, TX and drop outputs decoded from state
    always_comb begin
        w_next   = r_state;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;
        DROPPED  = 1'b0;
        BUSY     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (RX_VALID) begin
                    if (w_is_cmd) begin
                        w_next = S_GET_ADDR;
                    end else begin
                        DROPPED = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (RX_VALID) begin
                    w_next = r_write ? S_GET_DATA : S_APB_SETUP;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (RX_VALID) begin
                    w_next = S_APB_SETUP;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_APB_SETUP: begin
                PSEL    = 1'b1;
                PWRITE  = r_write;
                DROPPED = RX_VALID;
                w_next  = S_APB_ACCESS;
            end
            S_APB_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PWRITE  = r_write;
                DROPPED = RX_VALID;
                if (PREADY) begin
                    w_next = S_SEND_STATUS;
                end
            end
            S_SEND_STATUS: begin
                TX_VALID = 1'b1;
                TX_DATA  = r_err ? ST_ERR : ST_OK;
                DROPPED  = RX_VALID;
                if (TX_READY) begin
                    w_next = r_write ? S_IDLE : S_SEND_DATA;
                end
            end
            S_SEND_DATA: begin
                TX_VALID = 1'b1;
                TX_DATA  = r_rdata;
                DROPPED  = RX_VALID;
                if (TX_READY) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command fields, APB response capture and inter-byte timeout counter
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
            r_wdata <= 8'h00;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && RX_VALID && w_is_cmd) begin
                r_write <= (RX_DATA == CMD_WR);
            end
            if (r_state == S_GET_ADDR && RX_VALID) begin
                r_addr <= RX_DATA[ADDR_WIDTH-1:0];
            end
            if (r_state == S_GET_DATA && RX_VALID) begin
                r_wdata <= RX_DATA;
            end
            if (r_state == S_APB_ACCESS && PREADY) begin
                r_rdata <= PRDATA;
                r_err   <= PSLVERR;
            end
            // Any state change restarts the count, so entry to a GET state sees 0
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_getting && !RX_VALID) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_cmd_master.sv
// Self-checking bench for uart_apb_cmd_master: directed cases plus random
// commands checked against a memory-level command model and APB slave.
module tb_uart_apb_cmd_master;

    localparam int TMO = 1000;

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] wd;
        int         setup;
        int         acc;
    } xfer_t;

    logic       PCLK;
    logic       PRESET;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [4:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic       BUSY;
    logic       DROPPED;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [32];
    logic [7:0] model_mem [32];
    int         cfg_wait = 0;
    bit         cfg_err  = 0;
    int         rdy_mode = 0;
    xfer_t      log_q [$];
    logic [7:0] tx_q [$];
    int         psel_cnt    = 0;
    int         apb_stab    = 0;
    int         tx_stab     = 0;
    int         drop_cnt    = 0;

    uart_apb_cmd_master #(
        .ADDR_WIDTH     (5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .BUSY     (BUSY),
        .DROPPED  (DROPPED)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // APB slave: memory with configurable wait states and error response
    initial begin
        int         acc_n;
        int         s_setup;
        logic [4:0] s_addr;
        logic       s_wr;
        logic [7:0] s_wd;
        acc_n   = 0;
        s_setup = 0;
        s_addr  = '0;
        s_wr    = 1'b0;
        s_wd    = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL === 1'b1) psel_cnt++;
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                if (PADDR !== s_addr || PWRITE !== s_wr ||
                    (s_wr && PWDATA !== s_wd)) apb_stab++;
                if (acc_n == cfg_wait) begin
                    PREADY  = 1'b1;
                    PSLVERR = cfg_err;
                    PRDATA  = mem[PADDR];
                    if (PWRITE && !cfg_err) mem[PADDR] = PWDATA;
                    log_q.push_back('{PADDR, PWRITE, PWDATA,
                                      s_setup, acc_n + 1});
                end else begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'(($urandom));
                    PRDATA  = 8'($urandom);
                end
                acc_n++;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                acc_n   = 0;
                if (PSEL === 1'b1) begin
                    s_setup++;
                    s_addr = PADDR;
                    s_wr   = PWRITE;
                    s_wd   = PWDATA;
                end else begin
                    s_setup = 0;
                end
            end
        end
    end

    // TX_READY pattern: 0 always ready, 1 random, 2 stalled
    initial begin
        TX_READY = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            case (rdy_mode)
                0:       TX_READY = 1'b1;
                1:       TX_READY = 1'($urandom);
                default: TX_READY = 1'b0;
            endcase
        end
    end

    // TX sink: collects accepted bytes, flags changes while stalled
    initial begin
        bit         pend;
        logic [7:0] pend_d;
        pend   = 0;
        pend_d = '0;
        forever begin
            @(negedge PCLK);
            if (pend && !(TX_VALID === 1'b1 && TX_DATA === pend_d)) tx_stab++;
            if (TX_VALID === 1'b1 && TX_READY === 1'b1) begin
                tx_q.push_back(TX_DATA);
                pend = 0;
            end else if (TX_VALID === 1'b1) begin
                pend   = 1;
                pend_d = TX_DATA;
            end else begin
                pend = 0;
            end
            if (DROPPED === 1'b1) drop_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic d);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge PCLK);
        d = DROPPED;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
    endtask

    task automatic gap(input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) tick();
    endtask

    task automatic issue(input bit isw, input logic [7:0] a,
                         input logic [7:0] d, input int w,
                         input bit e, input int maxgap);
        logic dr;
        cfg_wait = w;
        cfg_err  = e;
        send_byte(isw ? 8'h57 : 8'h52, dr);
        chk("cmd_dropped", dr, 0);
        gap(maxgap);
        send_byte(a, dr);
        chk("addr_dropped", dr, 0);
        if (isw) begin
            gap(maxgap);
            send_byte(d, dr);
            chk("data_dropped", dr, 0);
        end
    endtask

    task automatic finish_cmd(input bit isw, input logic [7:0] a,
                              input logic [7:0] d, input int w,
                              input bit e);
        logic [4:0] ad;
        int         n;
        int         waited;
        xfer_t      x;
        ad     = a[4:0];
        n      = isw ? 1 : 2;
        waited = 0;
        while (!(tx_q.size() >= n && BUSY === 1'b0) && waited < 400) begin
            tick();
            waited++;
        end
        chk("resp_in_time", waited < 400, 1);
        chk("tx_count", tx_q.size(), n);
        if (tx_q.size() > 0) chk("tx_status", tx_q.pop_front(),
                                 e ? 8'h45 : 8'h4B);
        if (!isw && tx_q.size() > 0) chk("tx_rdata", tx_q.pop_front(),
                                         model_mem[ad]);
        tx_q.delete();
        chk("apb_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            x = log_q.pop_front();
            chk("apb_addr", x.addr, ad);
            chk("apb_write", x.wr, isw);
            if (isw) chk("apb_wdata", x.wd, d);
            chk("apb_setup", x.setup, 1);
            chk("apb_access", x.acc, w + 1);
        end
        log_q.delete();
        if (isw && !e) model_mem[ad] = d;
    endtask

    initial begin
        logic       dr;
        int         p0;
        bit         isw;
        bit         e;
        int         w;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 32; i++) begin
            mem[i]       = 8'($urandom);
            model_mem[i] = mem[i];
        end
        mem[1]       = 8'h3C;
        model_mem[1] = 8'h3C;
        PRESET   = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_txvalid", TX_VALID, 0);
        chk("rst_txdata", TX_DATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_dropped", DROPPED, 0);
        tick();
        PRESET = 1'b0;
        tick();

        // Zero-wait write with cycle-exact latency
        issue(1, 8'h03, 8'hA5, 0, 0, 0);
        @(negedge PCLK);
        chk("t1_setup_psel", PSEL, 1);
        chk("t1_setup_pen", PENABLE, 0);
        chk("t1_pwrite", PWRITE, 1);
        chk("t1_paddr", PADDR, 5'h03);
        chk("t1_pwdata", PWDATA, 8'hA5);
        tick();
        @(negedge PCLK);
        chk("t1_acc_pen", PENABLE, 1);
        chk("t1_acc_txv", TX_VALID, 0);
        tick();
        @(negedge PCLK);
        chk("t1_txvalid", TX_VALID, 1);
        chk("t1_txdata", TX_DATA, 8'h4B);
        chk("t1_psel_off", PSEL, 0);
        chk("t1_pwrite_off", PWRITE, 0);
        finish_cmd(1, 8'h03, 8'hA5, 0, 0);

        // Read with four wait states
        issue(0, 8'h01, 8'h00, 4, 0, 0);
        finish_cmd(0, 8'h01, 8'h00, 4, 0);

        // Slave error on write and read
        issue(1, 8'h02, 8'h11, 0, 1, 0);
        finish_cmd(1, 8'h02, 8'h11, 0, 1);
        issue(0, 8'h02, 8'h00, 0, 1, 0);
        finish_cmd(0, 8'h02, 8'h00, 0, 1);

        // Timeout after the command byte
        p0 = psel_cnt;
        send_byte(8'h57, dr);
        repeat (TMO - 1) tick();
        @(negedge PCLK);
        chk("tmo_busy_before", BUSY, 1);
        tick();
        @(negedge PCLK);
        chk("tmo_busy_after", BUSY, 0);
        chk("tmo_no_psel", psel_cnt - p0, 0);
        chk("tmo_no_tx", tx_q.size(), 0);
        tick();
        issue(0, 8'h00, 8'h00, 0, 0, 0);
        finish_cmd(0, 8'h00, 8'h00, 0, 0);

        // Unknown byte in IDLE, byte during APB access
        send_byte(8'h41, dr);
        chk("bad_cmd_dropped", dr, 1);
        @(negedge PCLK);
        chk("bad_cmd_busy", BUSY, 0);
        tick();
        issue(0, 8'h04, 8'h00, 5, 0, 0);
        tick();
        send_byte(8'h57, dr);
        chk("acc_rx_dropped", dr, 1);
        finish_cmd(0, 8'h04, 8'h00, 5, 0);

        // TX stall on status byte
        rdy_mode = 2;
        issue(1, 8'h06, 8'h5A, 0, 0, 0);
        p0 = 0;
        while (TX_VALID !== 1'b1 && p0 < 20) begin
            tick();
            p0++;
        end
        chk("stall_txv_seen", TX_VALID, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            chk("stall_txdata", TX_DATA, 8'h4B);
            tick();
        end
        rdy_mode = 0;
        finish_cmd(1, 8'h06, 8'h5A, 0, 0);

        // Reset while in APB access
        issue(0, 8'hFF, 8'h00, 20, 0, 0);
        repeat (3) tick();
        chk("rst_mid_pen_before", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("rst_mid_psel", PSEL, 0);
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_paddr", PADDR, 0);
        tick();
        PRESET = 1'b0;
        repeat (5) tick();
        chk("rst_mid_no_tx", tx_q.size(), 0);
        chk("rst_mid_no_xfer", log_q.size(), 0);
        issue(0, 8'h1F, 8'h00, 1, 0, 0);
        finish_cmd(0, 8'h1F, 8'h00, 1, 0);

        // Random commands with random gaps and TX back-pressure
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            isw = 1'($urandom);
            a   = 8'($urandom);
            d   = 8'($urandom);
            w   = int'($urandom_range(3, 0));
            e   = ($urandom_range(3, 0) == 0);
            issue(isw, a, d, w, e, 3);
            finish_cmd(isw, a, d, w, e);
        end
        rdy_mode = 0;

        chk("apb_stable", apb_stab, 0);
        chk("tx_stable", tx_stab, 0);
        chk("drop_total", drop_cnt, 2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
